// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO read-side stream consumer.
package fifo_stream_reader_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned BURST_CNT_W    = 16;
  localparam int unsigned OCC_W          = 2;
  localparam int unsigned CREDIT_W       = 3;
  localparam int unsigned MAX_CREDIT     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  // Slots already claimed: words sitting in the buffer plus the one on the FIFO bus.
  function automatic logic [CREDIT_W-1:0] credit_used(input logic [OCC_W-1:0] occ,
                                                      input logic inflight);
    return CREDIT_W'(occ) + CREDIT_W'(inflight);
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry FIFO-ordered valid/ready buffer; head entry drives the stream directly.
module stream_skid_buffer
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid
);

  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;
  logic [DATA_WIDTH-1:0] entry0_n;
  logic [DATA_WIDTH-1:0] entry1_n;
  logic [OCC_W-1:0]      occ_n;
  logic                  do_pop;

  // Next buffer contents; a simultaneous push and pop keeps occupancy unchanged.
  always_comb begin
    entry0_n = entry0;
    entry1_n = entry1;
    occ_n    = occ;
    do_pop   = pop && (occ != OCC_W'(0));
    case (occ)
      2'd0: begin
        if (push) begin
          entry0_n = push_data;
          occ_n    = 2'd1;
        end
      end
      2'd1: begin
        if (push && do_pop) begin
          entry0_n = push_data;
        end else if (push) begin
          entry1_n = push_data;
          occ_n    = 2'd2;
        end else if (do_pop) begin
          occ_n = 2'd0;
        end
      end
      2'd2: begin
        if (do_pop) begin
          entry0_n = entry1;
          if (push) begin
            entry1_n = push_data;
          end else begin
            occ_n = 2'd1;
          end
        end
      end
      default: occ_n = 2'd0;
    endcase
  end

  // Buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry0     <= '0;
      entry1     <= '0;
      occ        <= '0;
      head_valid <= 1'b0;
    end else begin
      entry0     <= entry0_n;
      entry1     <= entry1_n;
      occ        <= occ_n;
      head_valid <= (occ_n != OCC_W'(0));
    end
  end

  assign head_data = entry0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the async FIFO read port into a valid/ready stream with burst framing and a beat counter.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clock_read,
  input  logic                  read_reset_n,
  input  logic                  drain_enable,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam logic [BURST_CNT_W-1:0] LAST_IDX = BURST_CNT_W'(BURST_LEN - 1);

  state_e                 state;
  state_e                 state_n;
  logic                   inflight;
  logic [OCC_W-1:0]       occ;
  logic                   beat;
  logic                   credit_ok;
  logic [BURST_CNT_W-1:0] burst_cnt;

  assign beat      = out_valid && out_ready;
  // A beat leaving this cycle frees a slot for the word that lands next cycle.
  assign credit_ok = credit_used(occ, inflight) < (CREDIT_W'(MAX_CREDIT) + CREDIT_W'(beat));
  assign out_last  = (burst_cnt == LAST_IDX) && out_valid;

  // State register.
  always_ff @(posedge clock_read) begin
    if (!read_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; STOP drains landed and buffered words before going idle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (drain_enable) state_n = RUN;
      RUN:  if (!drain_enable) state_n = STOP;
      STOP: begin
        if (drain_enable) begin
          state_n = RUN;
        end else if (!inflight && (occ == OCC_W'(0))) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM outputs: pop strobe gated by state, FIFO flag and buffer credit.
  always_comb begin
    fifo_read_enable = 1'b0;
    busy             = (state != IDLE);
    if ((state == RUN) && !fifo_empty && credit_ok) begin
      fifo_read_enable = 1'b1;
    end
  end

  // In-flight flag: the popped word appears on fifo_read_data one cycle later.
  always_ff @(posedge clock_read) begin
    if (!read_reset_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_read_enable;
    end
  end

  // Burst position and total beat counter.
  always_ff @(posedge clock_read) begin
    if (!read_reset_n) begin
      burst_cnt  <= '0;
      word_count <= '0;
    end else if (beat) begin
      burst_cnt  <= (burst_cnt == LAST_IDX) ? '0 : burst_cnt + BURST_CNT_W'(1);
      word_count <= word_count + CNT_WIDTH'(1);
    end
  end

  stream_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk        (clock_read),
    .rst_n      (read_reset_n),
    .push       (inflight),
    .push_data  (fifo_read_data),
    .pop        (beat),
    .occ        (occ),
    .head_data  (out_data),
    .head_valid (out_valid)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed table plus corner-case sequences for fifo_stream_reader (BURST_LEN=4).
module tb_fifo_stream_reader;

  localparam int unsigned DW  = 16;
  localparam int unsigned BL  = 4;
  localparam int unsigned CW  = 32;
  localparam int          SRC = 4096;

  logic          clk = 1'b0;
  logic          read_reset_n;
  logic          drain_enable;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic [DW-1:0] fifo_read_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic [CW-1:0] word_count;

  logic [DW-1:0] src [SRC];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          force_empty;

  int checks   = 0;
  int failures = 0;

  logic          mon_en;
  int            mon_idx;
  int            mon_burst;
  int            pop_cnt;
  logic          stall_prev;
  logic [DW-1:0] stall_data;
  logic [DW-1:0] last_q [$];

  typedef struct {
    logic          drain;
    logic          ready;
    int            push_n;
    logic [DW-1:0] push_base;
    logic          exp_rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          exp_last;
    logic          exp_busy;
    logic [CW-1:0] exp_wc;
  } vec_t;

  vec_t tbl [18];

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .CNT_WIDTH (CW)
  ) dut (
    .clock_read       (clk),
    .read_reset_n     (read_reset_n),
    .drain_enable     (drain_enable),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_read_data   (fifo_read_data),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .busy             (busy),
    .word_count       (word_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  // FIFO read-port model: data follows an accepted pop by one cycle, junk otherwise.
  always @(posedge clk) begin
    if (fifo_read_enable && !fifo_empty) begin
      fifo_read_data <= src[rd_ptr];
      rd_ptr         <= rd_ptr + 1;
    end else begin
      fifo_read_data <= 16'hBAD0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      src[wr_ptr] = base + DW'(k);
      wr_ptr++;
    end
  endtask

  // Per-cycle scoreboard, called at the falling edge.
  task automatic monitor();
    check("pop_while_empty", 32'(fifo_read_enable && fifo_empty), 32'd0);
    check("credit", 32'((int'(dut.occ) + int'(dut.inflight)) <= 2), 32'd1);
    if (fifo_read_enable && !fifo_empty) pop_cnt++;
    if (mon_en) begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(stall_data));
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        check("beat_data", 32'(out_data), 32'(src[mon_idx]));
        check("beat_last", 32'(out_last), 32'(mon_burst == BL - 1));
        if (out_last) last_q.push_back(out_data);
        mon_idx++;
        mon_burst = (mon_burst + 1) % BL;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (mon_idx != wr_ptr && n < budget) begin
      step();
      n++;
    end
    check("drain_done", 32'(mon_idx), 32'(wr_ptr));
  endtask

  function automatic vec_t mk(input logic d, input logic r, input int pn, input logic [DW-1:0] pb,
                              input logic rd, input logic v, input logic [DW-1:0] dat,
                              input logic l, input logic b, input logic [CW-1:0] wc);
    vec_t t;
    t.drain = d; t.ready = r; t.push_n = pn; t.push_base = pb;
    t.exp_rd = rd; t.exp_valid = v; t.exp_data = dat; t.exp_last = l;
    t.exp_busy = b; t.exp_wc = wc;
    return t;
  endfunction

  initial begin
    int n;
    // Reset-then-enable with 4 preloaded words, followed by a stop in a pop cycle.
    tbl[0]  = mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0);
    tbl[2]  = mk(1, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0);
    tbl[3]  = mk(1, 1, 0, 16'h0000, 1, 1, 16'h0001, 0, 1, 0);
    tbl[4]  = mk(1, 1, 0, 16'h0000, 1, 1, 16'h0002, 0, 1, 1);
    tbl[5]  = mk(1, 1, 0, 16'h0000, 0, 1, 16'h0003, 0, 1, 2);
    tbl[6]  = mk(1, 1, 0, 16'h0000, 0, 1, 16'h0004, 1, 1, 3);
    tbl[7]  = mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 4);
    tbl[8]  = mk(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 4);
    tbl[9]  = mk(1, 1, 4, 16'h0C00, 1, 0, 16'h0000, 0, 1, 4);
    tbl[10] = mk(1, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 4);
    tbl[11] = mk(1, 1, 0, 16'h0000, 1, 1, 16'h0C00, 0, 1, 4);
    tbl[12] = mk(0, 1, 0, 16'h0000, 1, 1, 16'h0C01, 0, 1, 5);
    tbl[13] = mk(0, 1, 0, 16'h0000, 0, 1, 16'h0C02, 0, 1, 6);
    tbl[14] = mk(0, 1, 0, 16'h0000, 0, 1, 16'h0C03, 1, 1, 7);
    tbl[15] = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 8);
    tbl[16] = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8);
    tbl[17] = mk(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8);

    read_reset_n = 1'b0;
    drain_enable = 1'b0;
    out_ready    = 1'b0;
    force_empty  = 1'b0;
    mon_en       = 1'b1;
    mon_idx      = 0;
    mon_burst    = 0;
    pop_cnt      = 0;
    stall_prev   = 1'b0;
    stall_data   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 32'(fifo_read_enable), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wc", word_count, 32'd0);
    check("rst_data", 32'(out_data), 32'd0);

    read_reset_n = 1'b1;
    push_words(4, 16'h0001);

    for (int i = 0; i < 18; i++) begin
      drain_enable = tbl[i].drain;
      out_ready    = tbl[i].ready;
      push_words(tbl[i].push_n, tbl[i].push_base);
      @(negedge clk);
      check($sformatf("row%0d_rd_en", i), 32'(fifo_read_enable), 32'(tbl[i].exp_rd));
      check($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check($sformatf("row%0d_data", i), 32'(out_data), 32'(tbl[i].exp_data));
      check($sformatf("row%0d_last", i), 32'(out_last), 32'(tbl[i].exp_last));
      check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      check($sformatf("row%0d_wc", i), word_count, tbl[i].exp_wc);
      monitor();
      @(posedge clk);
      #1;
    end

    // Burst framing: 10 words from burst position 0, last on A3 and A7.
    last_q.delete();
    drain_enable = 1'b1;
    out_ready    = 1'b1;
    push_words(10, 16'h00A0);
    wait_drain(200);
    check("burst_last_n", 32'(last_q.size()), 32'd2);
    if (last_q.size() == 2) begin
      check("burst_last0", 32'(last_q[0]), 32'h00A3);
      check("burst_last1", 32'(last_q[1]), 32'h00A7);
    end
    check("burst_cnt_end", 32'(dut.burst_cnt), 32'd2);

    // Backpressure: only two pops may be issued while ready is low.
    out_ready = 1'b0;
    pop_cnt   = 0;
    push_words(6, 16'h0B00);
    repeat (10) step();
    check("bp_pops", 32'(pop_cnt), 32'd2);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_data", 32'(out_data), 32'h0B00);
    out_ready = 1'b1;
    wait_drain(100);
    check("bp_wc", word_count, 32'd24);

    // Random ready and FIFO gaps over 2000 words.
    for (int i = 0; i < 2000; i++) begin
      src[wr_ptr] = DW'($urandom);
      wr_ptr++;
    end
    n = 0;
    while (mon_idx != wr_ptr && n < 20000) begin
      out_ready   = 1'($urandom_range(1, 0));
      force_empty = ($urandom_range(9, 0) == 0);
      step();
      n++;
    end
    out_ready   = 1'b1;
    force_empty = 1'b0;
    check("rand_drain", 32'(mon_idx), 32'(wr_ptr));
    repeat (3) step();
    check("rand_wc", word_count, 32'd2024);

    // Reset while a word is buffered, one is landing, and another pop is issued.
    mon_en    = 1'b0;
    out_ready = 1'b0;
    push_words(4, 16'h0D00);
    @(negedge clk);
    check("mr_pop0", 32'(fifo_read_enable), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mr_pop1", 32'(fifo_read_enable), 32'd1);
    @(posedge clk); #1;
    out_ready    = 1'b1;
    read_reset_n = 1'b0;
    drain_enable = 1'b0;
    @(negedge clk);
    check("mr_pre_valid", 32'(out_valid), 32'd1);
    check("mr_pre_data", 32'(out_data), 32'h0D00);
    check("mr_pre_pop", 32'(fifo_read_enable), 32'd1);
    @(posedge clk); #1;
    read_reset_n = 1'b1;
    @(negedge clk);
    check("mr_rd_en", 32'(fifo_read_enable), 32'd0);
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_last", 32'(out_last), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_wc", word_count, 32'd0);
    check("mr_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    drain_enable = 1'b1;
    @(negedge clk);
    check("mr_ignored_valid", 32'(out_valid), 32'd0);
    check("mr_ignored_wc", word_count, 32'd0);
    @(posedge clk); #1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      n++;
    end
    check("mr_next_valid", 32'(out_valid), 32'd1);
    check("mr_next_data", 32'(out_data), 32'h0D03);
    @(posedge clk); #1;
    @(negedge clk);
    check("mr_next_wc", word_count, 32'd1);
    check("mr_after_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
